// File: rtl/gm_pkg.sv
// Shared types and constants for the guitar front-end note path.
package gm_pkg;

  localparam int GM_NOTE_W = 3;
  localparam logic [GM_NOTE_W-1:0] NOTE_OPEN = '0;

  typedef struct packed {
    logic                 on;
    logic [GM_NOTE_W-1:0] note;
  } note_event_t;

  typedef enum logic {
    IDLE,
    SOUNDING
  } enc_state_t;

endpackage

// File: rtl/strum_note_encoder_if.sv
// Note-event handshake from the encoder (master) to the tone/synth stage (slave).
interface strum_note_encoder_if #(
  parameter int NOTE_W = 3
);
  logic              event_valid;
  logic              event_ready;
  logic              event_on;
  logic [NOTE_W-1:0] event_note;

  modport master (
    output event_valid,
    output event_on,
    output event_note,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_on,
    input  event_note,
    output event_ready
  );
endinterface

// File: rtl/strum_note_encoder_fret_priority_encoder.sv
// Highest pressed fret wins; code is fret index + 1, 0 when nothing is pressed.
module fret_priority_encoder
  import gm_pkg::*;
#(
  parameter int NUM_FRETS = 5,
  parameter int NOTE_W    = 3
) (
  input  logic [NUM_FRETS-1:0] fret_level,
  output logic [NOTE_W-1:0]    code
);

  always_comb begin
    code = NOTE_OPEN;
    for (int i = 0; i < NUM_FRETS; i++) begin
      if (fret_level[i]) code = NOTE_W'(i + 1);
    end
  end

endmodule

// File: rtl/strum_note_encoder.sv
// Turns strum/mute pulses and fret levels into note-on/off events with a
// sustain timeout and a one-entry overwrite-on-full event register.
//
// state    | meaning
// IDLE     | no note sounding, strum starts one
// SOUNDING | note active, sustain counter running down to 1
module strum_note_encoder
  import gm_pkg::*;
#(
  parameter int NUM_FRETS      = 5,
  parameter int NOTE_W         = 3,
  parameter int SUSTAIN_CYCLES = 50000,
  parameter int SUS_W          = 16,
  parameter int DROP_W         = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_FRETS-1:0] fret_level,
  input  logic                 strum_pos,
  input  logic                 mute_pos,
  strum_note_encoder_if.master evt,
  output logic                 sounding,
  output logic [NOTE_W-1:0]    active_note,
  output logic [DROP_W-1:0]    dropped_count
);

  localparam logic [SUS_W-1:0] SUS_LOAD = SUS_W'(SUSTAIN_CYCLES);
  localparam logic [SUS_W-1:0] SUS_LAST = SUS_W'(1);

  enc_state_t        state_q, state_d;
  logic [SUS_W-1:0]  sus_q, sus_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [NOTE_W-1:0] fret_code;
  logic              queue;
  note_event_t       q_evt;
  note_event_t       pend_q;
  logic              valid_q;
  logic [DROP_W-1:0] drop_q;
  logic              accept;

  fret_priority_encoder #(
    .NUM_FRETS (NUM_FRETS),
    .NOTE_W    (NOTE_W)
  ) u_fret_enc (
    .fret_level (fret_level),
    .code       (fret_code)
  );

  // Mute beats strum; strum beats sustain expiry.
  always_comb begin
    state_d = state_q;
    sus_d   = sus_q;
    note_d  = note_q;
    queue   = 1'b0;
    q_evt   = '0;
    case (state_q)
      IDLE: begin
        if (strum_pos && !mute_pos) begin
          state_d    = SOUNDING;
          note_d     = fret_code;
          sus_d      = SUS_LOAD;
          queue      = 1'b1;
          q_evt.on   = 1'b1;
          q_evt.note = fret_code;
        end
      end
      SOUNDING: begin
        if (mute_pos || (!strum_pos && sus_q == SUS_LAST)) begin
          state_d    = IDLE;
          note_d     = NOTE_OPEN;
          sus_d      = '0;
          queue      = 1'b1;
          q_evt.on   = 1'b0;
          q_evt.note = note_q;
        end else if (strum_pos) begin
          note_d     = fret_code;
          sus_d      = SUS_LOAD;
          queue      = 1'b1;
          q_evt.on   = 1'b1;
          q_evt.note = fret_code;
        end else begin
          sus_d = sus_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sus_q   <= '0;
      note_q  <= NOTE_OPEN;
    end else begin
      state_q <= state_d;
      sus_q   <= sus_d;
      note_q  <= note_d;
    end
  end

  assign accept = valid_q && evt.event_ready;

  // A new event replaces an unaccepted one; that loss is counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else if (queue) begin
      valid_q <= 1'b1;
      pend_q  <= q_evt;
      if (valid_q && !evt.event_ready && drop_q != '1) drop_q <= drop_q + 1'b1;
    end else if (accept) begin
      valid_q <= 1'b0;
    end
  end

  assign evt.event_valid = valid_q;
  assign evt.event_on    = pend_q.on;
  assign evt.event_note  = pend_q.note;
  assign sounding        = (state_q == SOUNDING);
  assign active_note     = note_q;
  assign dropped_count   = drop_q;

endmodule

// File: doc/strum_note_encoder.md
Name: strum_note_encoder

Overview:
- Sits directly downstream of the input-conditioner instances on the guitar front end.
- Consumes the debounced fret levels plus the strum and mute edge pulses, and turns them into note-on/note-off events.
- Events leave through a valid/ready handshake to the tone/synth stage.
- Tracks the currently sounding note and a sustain timeout.

Parameters:
- NUM_FRETS, 5, number of conditioned fret button inputs.
- NOTE_W, 3, width of the note code; must satisfy 2^NOTE_W > NUM_FRETS.
- SUSTAIN_CYCLES, 50000, number of clk cycles a note sounds after a strum before an automatic note-off.
- SUS_W, 16, width of the sustain counter; must hold SUSTAIN_CYCLES.
- DROP_W, 8, width of the saturating dropped-event counter.

Ports:
- clk  in  1  system clock, the same clock as the conditioners.
- reset_n  in  1  asynchronous, active-low reset.
- fret_level  in  NUM_FRETS  conditioned fret levels (1 = pressed).
- strum_pos  in  1  one-cycle rising-edge pulse from the strum conditioner.
- mute_pos  in  1  one-cycle rising-edge pulse from the mute conditioner.
- event_valid  out  1  an event is presented.
- event_ready  in  1  the consumer accepts the event this cycle.
- event_on  out  1  1 = note-on, 0 = note-off.
- event_note  out  NOTE_W  note code carried by the event.
- sounding  out  1  a note is currently active.
- active_note  out  NOTE_W  code of the active note; 0 when not sounding.
- dropped_count  out  DROP_W  saturating count of overwritten pending events.

Behaviour:
- Reset (asynchronous, on reset_n low), all outputs 0:
  - event_valid, event_on, event_note, sounding, active_note, dropped_count, sustain counter all 0.
  - FSM goes to IDLE.
  - Reset asserted mid-operation discards any pending event without emitting it.
- Note code: index of the highest-numbered pressed fret plus 1, so fret_level=5'b00101 gives note 3. No fret pressed gives 0, meaning open string, which is still a valid note-on.
- Fret sampling: fret_level is sampled in the same cycle as strum_pos.
- FSM states: IDLE, SOUNDING.
  - IDLE + strum_pos -> SOUNDING:
    - active_note = code, sounding = 1.
    - Sustain counter loaded with SUSTAIN_CYCLES.
    - Queue note-on(code).
  - SOUNDING + strum_pos (retrigger) -> stays SOUNDING:
    - active_note updated, counter reloaded.
    - Queue note-on(new code); no intervening note-off.
  - SOUNDING + mute_pos -> IDLE: queue note-off(active_note); sounding = 0, active_note = 0.
  - SOUNDING, no strum, counter decrements each cycle. When the counter is 1 (the SUSTAIN_CYCLES-th cycle after the strum cycle), that cycle -> IDLE and queue note-off(active_note).
  - IDLE + mute_pos: ignored, no event.
- Simultaneous events in one cycle:
  - mute_pos and strum_pos together: mute wins; strum ignored.
  - strum_pos in the same cycle as sustain expiry: strum wins as a retrigger; no note-off.
- Event output register (one entry):
  - A queued event appears on event_valid/event_on/event_note the cycle after the triggering input (latency 1).
  - event_on/event_note hold stable while event_valid && !event_ready.
  - The event is consumed on the clock edge where event_valid && event_ready; event_valid drops the next cycle unless a new event is queued in that same cycle.
  - If an event is queued while a different unaccepted event is pending, the new event overwrites the old one and dropped_count increments, saturating at all-ones.
  - A queue in the same cycle as acceptance is not a drop: the new event loads and event_valid stays 1.
- Sustain counter width: SUS_W; no wrap, because the counter is only loaded with SUSTAIN_CYCLES and decrements to 1.

Decomposition:
- Shared package gm_pkg:
  - NOTE_OPEN = 0.
  - The event struct {on, note}.
  - The FSM state enum {IDLE, SOUNDING}.
- One natural sub-module: fret_priority_encoder (combinational, NUM_FRETS -> NOTE_W). Everything else stays in strum_note_encoder.

Test Plan:
All tests use SUSTAIN_CYCLES=8 and event_ready held 1 unless stated.
1. Reset, then fret_level=5'b00101 and a strum_pos pulse -> next cycle event_valid=1, event_on=1, event_note=3; sounding=1, active_note=3.
2. No further input after case 1 -> exactly 8 cycles after the strum, a note-off event with note 3; sounding=0, active_note=0.
3. Strum with fret_level=0, then strum with 5'b10000 three cycles later -> note-on 0, then note-on 5 with no note-off between; sustain expiry measured from the second strum.
4. event_ready=0; two strums (notes 2 then 4) before acceptance -> event_note=4 held stable, dropped_count=1; raising event_ready consumes it and event_valid drops the next cycle.
5. mute_pos and strum_pos in the same cycle while sounding note 2 -> note-off with note 2; IDLE. mute_pos while IDLE -> no event.
6. Pull reset_n low mid-sustain with an unaccepted pending event -> all outputs 0 immediately, no event emitted after release.
